// File: rtl/rv32i_dmem_avalon_bridge.sv
// Data-memory bridge: turns the core's split-phase dmem request into a single Avalon-MM transaction.
// Latency: a store retires after 1 stall cycle when there is no waitrequest; a load with read latency L retires after 1+L.
// Backpressure: waitrequest and pending read data hold dmem_wait high; dmem_en is only sampled while dmem_wait is low.
module rv32i_dmem_avalon_bridge #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] WINDOW_BYTES   = 32'h0001_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic        dmem_wait,
  output logic [31:0] dmem_rdata,
  output logic        dmem_badmem_e,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RDWAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

  state_t      state;
  logic [31:0] tmo_cnt;
  logic [31:0] rel_addr;
  logic        req_fault;
  logic [3:0]  req_be;
  logic        tmo_hit;

  // Store data arrives in WB, while the bus cycle is in flight, so it goes straight through.
  assign avm_writedata = dmem_wdata_delayed;

  // The wait budget is spent on this cycle if the transaction does not finish in it.
  assign tmo_hit = (TMO_LIMIT != 32'd0) && ((tmo_cnt + 32'd1) == TMO_LIMIT);

  // Decode the DX-stage request: byte lanes, alignment and address-window faults.
  always_comb begin
    rel_addr  = dmem_addr - BASE_ADDR;
    req_fault = 1'b0;
    req_be    = 4'b0000;
    case (dmem_size)
      3'd0: req_be = 4'b0001 << dmem_addr[1:0];
      3'd1: begin
        req_be    = 4'b0011 << dmem_addr[1:0];
        req_fault = dmem_addr[0];
      end
      3'd2: begin
        req_be    = 4'b1111;
        req_fault = |dmem_addr[1:0];
      end
      default: req_fault = 1'b1;
    endcase
    // Unsigned wrap makes addresses below the base land far outside the window.
    if (rel_addr >= WINDOW_BYTES) req_fault = 1'b1;
  end

  // Transaction FSM with registered bus and core-facing outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      tmo_cnt        <= 32'd0;
      dmem_wait      <= 1'b0;
      dmem_rdata     <= 32'd0;
      dmem_badmem_e  <= 1'b0;
      avm_address    <= 32'd0;
      avm_byteenable <= 4'b0000;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
    end else begin
      dmem_badmem_e <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          tmo_cnt <= 32'd0;
          if (dmem_en) begin
            if (req_fault) begin
              state         <= S_ERR;
              dmem_badmem_e <= 1'b1;
            end else begin
              state          <= S_ISSUE;
              dmem_wait      <= 1'b1;
              avm_address    <= {dmem_addr[31:2], 2'b00};
              avm_byteenable <= req_be;
              avm_read       <= ~dmem_wen;
              avm_write      <= dmem_wen;
            end
          end else begin
            state <= S_IDLE;
          end
        end

        S_ISSUE: begin
          if (!avm_waitrequest) begin
            // Command accepted: the strobe drops next cycle whatever happens.
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            if (avm_write || avm_readdatavalid) begin
              if (avm_read) dmem_rdata <= avm_readdata;
              state     <= S_DONE;
              dmem_wait <= 1'b0;
              tmo_cnt   <= 32'd0;
            end else if (tmo_hit) begin
              state         <= S_ERR;
              dmem_wait     <= 1'b0;
              dmem_badmem_e <= 1'b1;
              tmo_cnt       <= 32'd0;
            end else begin
              state   <= S_RDWAIT;
              tmo_cnt <= tmo_cnt + 32'd1;
            end
          end else if (tmo_hit) begin
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            state         <= S_ERR;
            dmem_wait     <= 1'b0;
            dmem_badmem_e <= 1'b1;
            tmo_cnt       <= 32'd0;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end

        S_RDWAIT: begin
          if (avm_readdatavalid) begin
            dmem_rdata <= avm_readdata;
            state      <= S_DONE;
            dmem_wait  <= 1'b0;
            tmo_cnt    <= 32'd0;
          end else if (tmo_hit) begin
            // Any response arriving after this point belongs to an abandoned read.
            state         <= S_ERR;
            dmem_wait     <= 1'b0;
            dmem_badmem_e <= 1'b1;
            tmo_cnt       <= 32'd0;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end

        default: begin
          state     <= S_IDLE;
          dmem_wait <= 1'b0;
          avm_read  <= 1'b0;
          avm_write <= 1'b0;
          tmo_cnt   <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_dmem_avalon_bridge.sv
// Bench for the dmem Avalon bridge: core-side driver, Avalon slave responder, bus and retire monitors.
// Expected bus commands and retire results are queued when a request is issued and popped by the monitors.
// The slave follows per-request wait/latency scripts; a global watchdog bounds the run.
module tb_rv32i_dmem_avalon_bridge;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam logic [31:0] WIN  = 32'h0000_1000;
  localparam int          TMO  = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmem_en;
  logic        dmem_wen;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata_delayed;
  logic        dmem_wait;
  logic [31:0] dmem_rdata;
  logic        dmem_badmem_e;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  always #5 clk = ~clk;

  rv32i_dmem_avalon_bridge #(
    .BASE_ADDR      (BASE),
    .WINDOW_BYTES   (WIN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .dmem_en            (dmem_en),
    .dmem_wen           (dmem_wen),
    .dmem_size          (dmem_size),
    .dmem_addr          (dmem_addr),
    .dmem_wdata_delayed (dmem_wdata_delayed),
    .dmem_wait          (dmem_wait),
    .dmem_rdata         (dmem_rdata),
    .dmem_badmem_e      (dmem_badmem_e),
    .avm_address        (avm_address),
    .avm_read           (avm_read),
    .avm_write          (avm_write),
    .avm_byteenable     (avm_byteenable),
    .avm_writedata      (avm_writedata),
    .avm_waitrequest    (avm_waitrequest),
    .avm_readdata       (avm_readdata),
    .avm_readdatavalid  (avm_readdatavalid)
  );

  typedef struct { logic [31:0] addr; logic [3:0] be; bit we; logic [31:0] wdata; } bus_t;
  typedef struct { bit err; bit load; logic [31:0] data; } rsp_t;
  typedef struct { int w; int l; bit noresp; logic [31:0] data; } slv_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];
  slv_t slv_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   prev_wait = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Avalon slave: c counts cycles from the first cycle the command is up.
  initial begin : slave
    slv_t s;
    int   c;
    bit   rd;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'h0;
    forever begin
      @(posedge clk); #2;
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
      if (!reset && (avm_read || avm_write) && slv_q.size() > 0) begin
        s  = slv_q.pop_front();
        rd = avm_read;
        c  = 0;
        forever begin
          avm_waitrequest   = (c < s.w);
          avm_readdatavalid = rd && !s.noresp && (c == s.w + s.l);
          if (avm_readdatavalid) avm_readdata = s.data;
          if (c >= s.w + (rd ? s.l : 0)) break;
          @(posedge clk); #2;
          avm_waitrequest   = 1'b0;
          avm_readdatavalid = 1'b0;
          avm_readdata      = $urandom;
          c++;
          if (reset || (c <= s.w && !(avm_read || avm_write))) break;
        end
      end
    end
  end

  // Bus monitor: every accepted command must match the next expected one.
  always @(negedge clk) begin
    bus_t b;
    if (!reset && (avm_read || avm_write) && !avm_waitrequest) begin
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_unexpected: addr=%h rd=%b wr=%b with nothing expected", avm_address, avm_read, avm_write);
      end else begin
        b = bus_q.pop_front();
        check("bus_cmd", 64'({avm_address, avm_byteenable, avm_write, avm_read}),
              64'({b.addr, b.be, b.we, !b.we}));
        if (b.we) check("bus_wdata", 64'(avm_writedata), 64'(b.wdata));
      end
    end
  end

  // Retire monitor: an error pulse or the end of a stall is the response to the oldest request.
  always @(negedge clk) begin
    rsp_t r;
    if (reset) begin
      prev_wait = 1'b0;
    end else begin
      if (dmem_badmem_e || (prev_wait && !dmem_wait)) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: badmem=%b wait=%b with no request outstanding", dmem_badmem_e, dmem_wait);
        end else begin
          r = rsp_q.pop_front();
          check("rsp_badmem", 64'(dmem_badmem_e), 64'(r.err));
          if (dmem_badmem_e) check("rsp_err_wait", 64'(dmem_wait), 64'd0);
          if (!r.err && r.load) check("rsp_rdata", 64'(dmem_rdata), 64'(r.data));
        end
      end
      prev_wait = dmem_wait;
    end
  end

  task automatic idle(input int n);
    dmem_en = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Core side: present a request in DX, store data in WB, hold until the stall ends.
  // w = waitrequest cycles, l = read latency after acceptance, noresp = read data never returns.
  task automatic do_req(input bit wen, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input int w, input int l, input bit noresp,
                        input logic [31:0] rdata);
    logic [31:0] rel;
    int unsigned off;
    bit          fault;
    bit          tmo;
    bit          accepted;
    logic [3:0]  be;
    int          exp_stall;
    int          stall;
    rel   = addr - BASE;
    off   = addr % 4;
    fault = (size > 3'd2) || (size == 3'd1 && off % 2 != 0) || (size == 3'd2 && off != 0) || (rel >= WIN);
    case (size)
      3'd0:    be = 4'(1 << off);
      3'd1:    be = 4'(3 << off);
      default: be = 4'hF;
    endcase
    accepted = !fault && (w + 1 <= TMO);
    tmo      = !fault && (!accepted || (!wen && noresp));
    if (fault)      exp_stall = 0;
    else if (tmo)   exp_stall = TMO;
    else if (wen)   exp_stall = w + 1;
    else            exp_stall = w + 1 + l;
    if (!fault) slv_q.push_back('{w: w, l: (wen || noresp) ? 0 : l, noresp: noresp, data: rdata});
    if (accepted) bus_q.push_back('{addr: addr & 32'hFFFF_FFFC, be: be, we: wen, wdata: wdata});
    rsp_q.push_back('{err: fault || tmo, load: !wen, data: rdata});

    dmem_en            = 1'b1;
    dmem_wen           = wen;
    dmem_size          = size;
    dmem_addr          = addr;
    dmem_wdata_delayed = $urandom;
    @(posedge clk); #1;
    dmem_wdata_delayed = wdata;
    stall = 0;
    while (dmem_wait && stall < 64) begin
      // Stray requests during a stall must be ignored.
      dmem_en   = 1'($urandom_range(0, 1));
      dmem_wen  = 1'($urandom_range(0, 1));
      dmem_size = 3'($urandom_range(0, 7));
      dmem_addr = $urandom;
      stall++;
      @(posedge clk); #1;
    end
    dmem_en = 1'b0;
    check("stall_cycles", 64'(stall), 64'(exp_stall));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] a;
    logic [2:0]  sz;
    int          k;
    int          w;
    int          l;
    bit          wen;
    bit          nr;

    reset              = 1'b1;
    dmem_en            = 1'b0;
    dmem_wen           = 1'b0;
    dmem_size          = 3'd0;
    dmem_addr          = 32'h0;
    dmem_wdata_delayed = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_wait",   64'(dmem_wait),      64'd0);
    check("reset_rd_wr",  64'({avm_read, avm_write}), 64'd0);
    check("reset_addr",   64'(avm_address),    64'd0);
    check("reset_be",     64'(avm_byteenable), 64'd0);
    check("reset_rdata",  64'(dmem_rdata),     64'd0);
    check("reset_badmem", 64'(dmem_badmem_e),  64'd0);
    reset = 1'b0;
    idle(2);

    // Directed cases.
    do_req(1'b0, 3'd2, BASE + 32'h100, 32'h0, 0, 2, 1'b0, 32'hDEAD_BEEF);
    idle(1);
    do_req(1'b1, 3'd0, BASE + 32'h203, 32'hAA00_0000, 3, 0, 1'b0, 32'h0);
    idle(1);
    do_req(1'b0, 3'd1, BASE + 32'h101, 32'h0, 0, 0, 1'b0, 32'h1234_5678);
    do_req(1'b0, 3'd2, BASE + WIN,     32'h0, 0, 0, 1'b0, 32'h1111_1111);
    do_req(1'b0, 3'd2, BASE - 32'd4,   32'h0, 0, 0, 1'b0, 32'h2222_2222);
    do_req(1'b0, 3'd2, BASE + WIN - 32'd4, 32'h0, 1, 1, 1'b0, 32'hCAFE_F00D);
    do_req(1'b1, 3'd2, BASE + 32'h10, 32'h0BAD_F00D, 0, 0, 1'b0, 32'h0);
    do_req(1'b0, 3'd2, BASE + 32'h14, 32'h0, 0, 0, 1'b0, 32'h5A5A_A5A5);
    do_req(1'b0, 3'd3, BASE + 32'h20, 32'h0, 0, 0, 1'b0, 32'h3333_3333);
    do_req(1'b0, 3'd2, BASE + 32'h102, 32'h0, 0, 0, 1'b0, 32'h4444_4444);
    do_req(1'b1, 3'd1, BASE + 32'h102, 32'h0000_BEEF, 0, 0, 1'b0, 32'h0);
    do_req(1'b1, 3'd0, BASE + WIN - 32'd1, 32'h7700_0000, 2, 0, 1'b0, 32'h0);
    do_req(1'b0, 3'd2, BASE + 32'h40, 32'h0, 1, 0, 1'b1, 32'h6666_6666);
    do_req(1'b1, 3'd2, BASE + 32'h44, 32'h8888_8888, 100, 0, 1'b0, 32'h0);
    do_req(1'b0, 3'd0, BASE + 32'h45, 32'h0, 0, 0, 1'b0, 32'h0000_9900);
    idle(2);

    // Reset while a load waits for read data.
    slv_q.push_back('{w: 0, l: 0, noresp: 1'b1, data: 32'h0});
    bus_q.push_back('{addr: BASE + 32'h80, be: 4'hF, we: 1'b0, wdata: 32'h0});
    dmem_en   = 1'b1;
    dmem_wen  = 1'b0;
    dmem_size = 3'd2;
    dmem_addr = BASE + 32'h80;
    @(posedge clk); #1;
    dmem_en = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_wait", 64'(dmem_wait), 64'd1);
    reset = 1'b1;
    #1;
    check("midreset_wait",  64'(dmem_wait), 64'd0);
    check("midreset_rd_wr", 64'({avm_read, avm_write}), 64'd0);
    check("midreset_addr",  64'(avm_address), 64'd0);
    check("midreset_be",    64'(avm_byteenable), 64'd0);
    check("midreset_rdata", 64'(dmem_rdata), 64'd0);
    rsp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // Randomized traffic with occasional faults and timeouts.
    for (int i = 0; i < 300; i++) begin
      k   = $urandom_range(0, 19);
      wen = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      if (k == 0)      a = BASE - 32'($urandom_range(1, 64));
      else if (k == 1) a = BASE + WIN + 32'($urandom_range(0, 64));
      else             a = BASE + 32'($urandom_range(0, 32'(WIN - 32'd1)));
      if ($urandom_range(0, 3) != 0 && sz == 3'd1) a = a & 32'hFFFF_FFFE;
      if ($urandom_range(0, 3) != 0 && sz == 3'd2) a = a & 32'hFFFF_FFFC;
      nr = 1'b0;
      if (wen) begin
        w = $urandom_range(0, 3);
        l = 0;
        if (k == 2) w = 100;
      end else begin
        w  = $urandom_range(0, 2);
        l  = $urandom_range(0, 2 - w);
        nr = (k == 2);
      end
      do_req(wen, sz, a, $urandom, w, l, nr, $urandom);
      idle($urandom_range(0, 1) * $urandom_range(0, 2));
    end

    idle(4);
    check("bus_q_empty", 64'(bus_q.size()), 64'd0);
    check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    check("slv_q_empty", 64'(slv_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
